// File: rtl/md_scheduler.sv
// -----------------------------------------------------------------------------
// md_scheduler
//
// Multiply/divide controller for the pipelined MIPS core. Lives in the E stage
// next to the ALU and owns the architectural HI/LO registers.
//
// Every mult/multu/div/divu computes its result in the cycle it is accepted.
// That result is parked in pending registers, and the unit then reports busy for
// a fixed number of cycles. This mimics the timing of an iterative unit, and
// HI/LO only change when that busy window closes. mthi/mtlo write HI/LO
// directly. mfhi/mflo read them combinationally through MDOut.
//
// Ports
//   clk       in   1   system clock
//   reset     in   1   asynchronous, active-low reset
//   E_en      in   1   E-stage instruction valid (not a bubble)
//   E_MDOp    in   4   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi,
//                      6 mflo, 7 mthi, 8 mtlo, 9-15 none
//   E_A       in  32   rs operand (forwarded)
//   E_B       in  32   rt operand (forwarded)
//   D_MDuse   in   1   D-stage instruction is an MD op
//   busy      out  1   multiply/divide sequence in progress
//   start     out  1   a multiply/divide is accepted at the next edge
//   HI, LO    out 32   architectural HI/LO
//   MDOut     out 32   HI for mfhi, LO for mflo, else 0
//   stall_md  out  1   hold the MD op waiting in D
// -----------------------------------------------------------------------------
module md_scheduler #(
  parameter int MULT_CYCLES = 5,   // busy cycles for mult/multu, >= 1
  parameter int DIV_CYCLES  = 10   // busy cycles for div/divu,   >= 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_en,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_MDuse,
  output logic        busy,
  output logic        start,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut,
  output logic        stall_md
);

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;        // remaining busy cycles while in S_RUN
  logic               busy_q;
  logic [31:0]        hi_q, lo_q;
  logic [31:0]        pend_hi_q, pend_lo_q;
  logic               pend_wr_q;    // 0 for divide-by-zero: leave HI/LO alone

  // ---------------------------------------------------------------------------
  // Op decode
  // ---------------------------------------------------------------------------
  logic is_muldiv, is_div, is_signed;

  assign is_muldiv = E_MDOp inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};
  assign is_div    = E_MDOp inside {OP_DIV, OP_DIVU};
  assign is_signed = E_MDOp inside {OP_MULT, OP_DIV};

  // busy_q is the only gate: completion and a new start can never meet on
  // the same edge, because start needs busy_q == 0.
  assign start = E_en & is_muldiv & ~busy_q;

  // ---------------------------------------------------------------------------
  // Result datapath (only captured when start is high)
  // ---------------------------------------------------------------------------
  logic [63:0] ext_a, ext_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b, divisor;
  logic [31:0] uq, ur, quot, rem;
  logic [31:0] pend_hi_d, pend_lo_d;
  logic        pend_wr_d;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path through the block can leave it unassigned and infer a latch.
  always_comb begin
    ext_a     = '0;
    ext_b     = '0;
    prod      = '0;
    a_neg     = 1'b0;
    b_neg     = 1'b0;
    mag_a     = '0;
    mag_b     = '0;
    divisor   = 32'd1;
    uq        = '0;
    ur        = '0;
    quot      = '0;
    rem       = '0;
    pend_hi_d = '0;
    pend_lo_d = '0;
    pend_wr_d = 1'b0;

    // Signed and unsigned multiply share one 64x64 multiplier. The operands
    // are sign- or zero-extended, and the low 64 bits of the product are
    // exact in both cases.
    ext_a = {{32{is_signed & E_A[31]}}, E_A};
    ext_b = {{32{is_signed & E_B[31]}}, E_B};
    prod  = ext_a * ext_b;

    // Signed divide runs on magnitudes, and the signs are fixed up afterwards.
    // |0x80000000| is still 0x80000000 as an unsigned number, so the
    // 0x80000000 / -1 overflow case comes out as LO=0x80000000, HI=0 on its own.
    a_neg   = is_signed & E_A[31];
    b_neg   = is_signed & E_B[31];
    mag_a   = a_neg ? (~E_A + 32'd1) : E_A;
    mag_b   = b_neg ? (~E_B + 32'd1) : E_B;
    divisor = (mag_b == 32'd0) ? 32'd1 : mag_b;   // keeps the divider X-free on /0
    uq      = mag_a / divisor;
    ur      = mag_a % divisor;
    quot    = (a_neg ^ b_neg) ? (~uq + 32'd1) : uq;
    rem     = a_neg ? (~ur + 32'd1) : ur;         // remainder follows the dividend

    if (is_div) begin
      pend_hi_d = rem;
      pend_lo_d = quot;
      pend_wr_d = (E_B != 32'd0);
    end else begin
      pend_hi_d = prod[63:32];
      pend_lo_d = prod[31:0];
      pend_wr_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer and HI/LO
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. Every register
  // then samples pre-edge values, whatever order the statements are in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            busy_q    <= 1'b1;
            cnt_q     <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
          end else if (E_en && (E_MDOp == OP_MTHI)) begin
            hi_q <= E_A;
          end else if (E_en && (E_MDOp == OP_MTLO)) begin
            lo_q <= E_A;
          end
        end

        S_RUN: begin
          // Any ops presented while running are ignored. The stall logic
          // keeps them out of E in the first place.
          if (cnt_q == CNT_W'(1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy     = busy_q;
  assign HI       = hi_q;
  assign LO       = lo_q;
  assign stall_md = D_MDuse & (start | busy_q);

  // No forwarding from a same-cycle mthi/mtlo: reads see the registered values.
  always_comb begin
    MDOut = '0;
    if (E_MDOp == OP_MFHI)      MDOut = hi_q;
    else if (E_MDOp == OP_MFLO) MDOut = lo_q;
  end

endmodule
